// File: rtl/snake_pkg.sv
`default_nettype none
// ============================================================================
// Module      : snake_pkg
// Description : Shared types and constants for the snake game and its
//               inter-board direction link.
// Revision    : 1.0 - initial release
// ============================================================================
package snake_pkg;

    typedef enum logic [2:0] {
        DIR_NONE  = 3'd0,
        DIR_UP    = 3'd1,
        DIR_DOWN  = 3'd2,
        DIR_RIGHT = 3'd3,
        DIR_LEFT  = 3'd4
    } dir_t;

    localparam int         DIR_CODE_W   = 3;
    localparam int         CLKS_PER_BIT = 564;   // 65 MHz / 115200 baud
    localparam logic [3:0] SYNC_NIBBLE  = 4'hA;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_tx_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_tx_byte.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_byte
// Description : UART 8N1 byte serializer with load/busy handshake; accepts a
//               new byte on the last stop-bit cycle for gapless frames.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_byte #(
    parameter int CLKS_PER_BIT = snake_pkg::CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] data,
    output logic       tx,
    output logic       busy,
    output logic       idle,
    output logic       frame_end
);
    import snake_pkg::*;

    localparam int                CNT_W  = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]  C_LAST = CNT_W'(CLKS_PER_BIT - 1);

    uart_tx_state_t     r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [2:0]         r_idx;
    logic [7:0]         r_data;
    logic               r_tx;
    logic               r_busy;

    logic               w_last;
    logic               w_accept;

    assign w_last    = (r_cnt == C_LAST);
    assign idle      = (r_state == IDLE);
    assign frame_end = (r_state == STOP) && w_last;
    assign w_accept  = load && (idle || frame_end);
    assign tx        = r_tx;
    assign busy      = r_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_idx   <= 3'd0;
            r_data  <= 8'd0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
        end else if (w_accept) begin
            r_data  <= data;
            r_state <= START;
            r_cnt   <= '0;
            r_idx   <= 3'd0;
            r_tx    <= 1'b0;
            r_busy  <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                end
                START: begin
                    if (w_last) begin
                        r_cnt   <= '0;
                        r_idx   <= 3'd0;
                        r_state <= DATA;
                        r_tx    <= r_data[0];
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (w_last) begin
                        r_cnt <= '0;
                        if (r_idx == 3'd7) begin
                            r_state <= STOP;
                            r_tx    <= 1'b1;
                        end else begin
                            r_idx <= r_idx + 3'd1;
                            r_tx  <= r_data[r_idx + 3'd1];
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                STOP: begin
                    // A pending load on the last cycle was taken above.
                    if (w_last) begin
                        r_cnt   <= '0;
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/snake_dir_tx.sv
`default_nettype none
// ============================================================================
// Module      : snake_dir_tx
// Description : Samples the local direction on each game tick and sends it to
//               the peer board as one UART byte {SYNC, seq, dir}.
// Revision    : 1.0 - initial release
// ============================================================================
module snake_dir_tx #(
    parameter int         CLKS_PER_BIT = snake_pkg::CLKS_PER_BIT,
    parameter logic [3:0] SYNC_NIBBLE  = snake_pkg::SYNC_NIBBLE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_div,
    input  logic             en,
    input  snake_pkg::dir_t  dir,
    output logic             tx,
    output logic             busy,
    output logic             overrun
);
    import snake_pkg::*;

    logic                   r_clk_div_prv;
    logic                   r_seq;
    logic                   r_pend_v;
    dir_t                   r_pend_dir;
    logic                   r_overrun;

    logic                   w_tick;
    logic                   w_idle;
    logic                   w_frame_end;
    logic                   w_launch;
    logic [DIR_CODE_W-1:0]  w_launch_code;
    logic [7:0]             w_byte;

    assign w_tick        = en & clk_div & ~r_clk_div_prv;
    // A held pending byte always goes first; a fresh tick launches directly only from idle.
    assign w_launch      = r_pend_v ? (w_idle | w_frame_end) : (w_idle & w_tick);
    assign w_launch_code = r_pend_v ? r_pend_dir : dir;
    assign w_byte        = {SYNC_NIBBLE, r_seq, w_launch_code};
    assign overrun       = r_overrun;

    uart_tx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_ser (
        .clk       (clk),
        .rst       (rst),
        .load      (w_launch),
        .data      (w_byte),
        .tx        (tx),
        .busy      (busy),
        .idle      (w_idle),
        .frame_end (w_frame_end)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_clk_div_prv <= 1'b1;
            r_seq         <= 1'b0;
            r_pend_v      <= 1'b0;
            r_pend_dir    <= DIR_NONE;
            r_overrun     <= 1'b0;
        end else begin
            r_clk_div_prv <= clk_div;
            if (w_launch) begin
                r_seq <= ~r_seq;
            end
            if (w_tick && (!w_idle || r_pend_v)) begin
                r_pend_dir <= dir;
                r_pend_v   <= 1'b1;
                if (!w_idle && r_pend_v) begin
                    r_overrun <= 1'b1;
                end
            end else if (w_launch && r_pend_v) begin
                r_pend_v <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire
